seg7_mux_pwm_driver: RTL
========================

Name: seg7_mux_pwm_driver

Overview:
- Parametrised multiplexed seven-segment display driver with per-frame double-buffered digit loading, PWM brightness and anti-ghosting blanking.
- Next generation of the display back end inside the Clock top level. Generalises the fixed 4-digit, 8-bit-brightness path to N digits with configurable refresh and PWM resolution.
- Sits between the time-keeping logic, which produces digit values and the decimal-point mask, and the board anode/segment pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..16).
- REFRESH_DIV, 1024, Clk_100M cycles per digit slot; must be a multiple of 2**PWM_BITS and greater than BLANK_CYCLES.
- PWM_BITS, 8, brightness resolution in bits.
- BLANK_CYCLES, 2, cycles at the start of each slot with all drivers off.

Ports:
- Clk_100M  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- Digits_In  in  4*NUM_DIGITS  hex value per digit; digit 0 = [3:0] = rightmost.
- Dp_In  in  NUM_DIGITS  decimal-point enable per digit.
- Load_Valid  in  1  new Digits_In/Dp_In offered.
- Load_Ready  out  1  shadow buffer free.
- Brightness  in  PWM_BITS  duty control; 0 = off, all-ones = fully on.
- Frame_Start  out  1  one-cycle pulse when the active buffer updates (start of digit 0 slot).
- SegmentDrivers  out  NUM_DIGITS  anode enables, active-low.
- SevenSegment  out  8  {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (async assert, sync release):
  - slot_cnt = 0, digit_idx = 0.
  - Active and shadow buffers = all zero; pending = 0.
  - Load_Ready = 1, Frame_Start = 0.
  - SegmentDrivers = all ones; SevenSegment = 8'hFF.
- Timebase:
  - slot_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit_idx increments modulo NUM_DIGITS.
- Frame boundary: the cycle where slot_cnt == REFRESH_DIV-1 and digit_idx == NUM_DIGITS-1.
- Load handshake:
  - Load_Ready = !pending.
  - Capture into shadow when Load_Valid && Load_Ready; pending is set next cycle, so Load_Ready drops one cycle after capture.
  - Valid held without Ready: the data must stay stable. The driver samples only on handshake.
- Update at frame boundary:
  - If pending: shadow→active, pending clears, and Frame_Start pulses in the first cycle of the new frame.
  - Frame_Start pulses every frame whether or not an update occurred.
  - Capture and boundary in the same cycle with pending = 0: the capture goes to shadow and transfers at the next boundary.
- Lit condition:
  - phase = slot_cnt mod 2**PWM_BITS.
  - Lit iff slot_cnt >= BLANK_CYCLES AND (phase < Brightness OR Brightness == all ones).
  - Brightness == 0 means never lit.
  - Brightness is sampled live, with no buffering.
- Outputs (registered, 1-cycle latency from counter state):
  - If lit: SegmentDrivers = ~(1 << digit_idx), SevenSegment = {~dp, ~hexdecode(active digit)}.
  - Else: SegmentDrivers = all ones, SevenSegment = 8'hFF.
- Hex decode: full 0-F. Standard glyphs; A, b, C, d, E, F for 10-15.
- Reset mid-frame: immediate blank, and any pending data is discarded.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit is blanked, with drivers off for its whole slot, when its value is 0, its dp is clear, and all higher-index digits are also blanked this way.
  - Digit 0 is never blanked.
  - Blanking is evaluated on the active buffer.
- Undefined: all digits are always displayed.

Decomposition:
- Package seg7_pkg:
  - SEG_* glyph constants (active-high a..g) and the SEG_BLANK constant.
  - hex_to_seg function.
  - Localparam helper for slot_cnt width: clog2(REFRESH_DIV).
- Sub-module seg7_timebase: slot_cnt, digit_idx, frame-boundary and lit generation.
- The top holds the buffers, the handshake and the output registers.

Test Plan:
- Bench parameters: NUM_DIGITS=4, REFRESH_DIV=16, PWM_BITS=2, BLANK_CYCLES=2.
- Reset: hold Reset_n=0 mid-frame. SegmentDrivers=4'hF and SevenSegment=8'hFF in the same cycle; Load_Ready=1.
- Load: load Digits_In=16'h1234 with Dp_In=4'b0100.
  - Load_Ready drops one cycle after capture.
  - After the next Frame_Start, digit 0 shows 8'h99 (4) and digit 2 shows 8'h24 ("2" with dp on).
  - Load_Ready returns to 1.
- Back-to-back loads: offer 16'hABCD then 16'h0000 in consecutive cycles. The second is stalled (Ready=0) until the boundary. Displayed order is ABCD for one full frame, then 0000.
- Brightness:
  - Brightness=2'b11: each digit lit for cycles 2..15 of its slot.
  - Brightness=2'b01: lit only where phase==0 and slot_cnt>=2, i.e. cycles 4, 8, 12.
  - Brightness=0: SegmentDrivers stays 4'hF.
- Leading-zero blanking: with SEG7_LEADING_ZERO_BLANK_EN defined, load 16'h0050. Digits 3 and 2 stay off; digit 1 shows "5" and digit 0 shows "0". The same build without the macro shows "0050".

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph constants and helpers for the multiplexed seven-segment driver.
// Glyphs are active-high in {g,f,e,d,c,b,a} order; inversion to pin polarity happens in the top.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_mux_pwm_driver_if.sv
// Digit-load handshake between the time-keeping logic (master) and the display driver (slave).
interface seg7_mux_pwm_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] Digits_In;
    logic [NUM_DIGITS-1:0]   Dp_In;
    logic                    Load_Valid;
    logic                    Load_Ready;

    modport master (output Digits_In, output Dp_In, output Load_Valid, input Load_Ready);
    modport slave  (input Digits_In, input Dp_In, input Load_Valid, output Load_Ready);
endinterface

// File: rtl/seg7_timebase.sv
// Slot counter and digit scanner; flags the frame boundary and whether the current cycle is lit.
module seg7_timebase
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1024,
    parameter int PWM_BITS     = 8,
    parameter int BLANK_CYCLES = 2,
    localparam int CW = cnt_width(REFRESH_DIV),
    localparam int IW = cnt_width(NUM_DIGITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [IW-1:0]       digit_idx,
    output logic                frame_boundary,
    output logic                lit
);

    logic [CW-1:0]       slot_cnt_q, slot_cnt_d;
    logic [IW-1:0]       digit_idx_q, digit_idx_d;
    logic [PWM_BITS-1:0] phase;
    logic                slot_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= '0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    always_comb begin
        slot_end    = (slot_cnt_q == CW'(REFRESH_DIV - 1));
        slot_cnt_d  = slot_cnt_q + CW'(1);
        digit_idx_d = digit_idx_q;
        if (slot_end) begin
            slot_cnt_d  = '0;
            digit_idx_d = (digit_idx_q == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + IW'(1);
        end
        frame_boundary = slot_end && (digit_idx_q == IW'(NUM_DIGITS - 1));
        // REFRESH_DIV is a multiple of the PWM period, so the low bits are the PWM phase.
        phase = slot_cnt_q[PWM_BITS-1:0];
        lit   = (slot_cnt_q >= CW'(BLANK_CYCLES)) && ((phase < brightness) || (&brightness));
    end

    assign digit_idx = digit_idx_q;

endmodule

// File: rtl/seg7_mux_pwm_driver.sv
// N-digit multiplexed seven-segment driver with double-buffered loading and PWM dimming.
// Define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg7_mux_pwm_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1024,
    parameter int PWM_BITS     = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    Clk_100M,
    input  logic                    Reset_n,
    seg7_mux_pwm_driver_if.slave    ld,
    input  logic [PWM_BITS-1:0]     Brightness,
    output logic                    Frame_Start,
    output logic [NUM_DIGITS-1:0]   SegmentDrivers,
    output logic [7:0]              SevenSegment
);

    localparam int IW = cnt_width(NUM_DIGITS);

    logic [IW-1:0]           digit_idx;
    logic                    frame_boundary;
    logic                    lit;

    logic [4*NUM_DIGITS-1:0] active_dig_q, active_dig_d, shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d, shadow_dp_q, shadow_dp_d;
    logic                    pending_q, pending_d;
    logic                    frame_start_q, frame_start_d;
    logic [NUM_DIGITS-1:0]   seg_drv_q, seg_drv_d;
    logic [7:0]              seven_seg_q, seven_seg_d;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    capture;

    seg7_timebase #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .PWM_BITS    (PWM_BITS),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timebase (
        .clk           (Clk_100M),
        .rst_n         (Reset_n),
        .brightness    (Brightness),
        .digit_idx     (digit_idx),
        .frame_boundary(frame_boundary),
        .lit           (lit)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic run;
    // A digit is suppressed only while every digit above it is also a suppressed zero.
    always_comb begin
        blank_mask = '0;
        run        = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run           = run && (active_dig_q[4*i +: 4] == 4'h0) && !active_dp_q[i];
            blank_mask[i] = run;
        end
    end
`else
    assign blank_mask = '0;
`endif

    always_ff @(posedge Clk_100M or negedge Reset_n) begin
        if (!Reset_n) begin
            active_dig_q  <= '0;
            active_dp_q   <= '0;
            shadow_dig_q  <= '0;
            shadow_dp_q   <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            seg_drv_q     <= '1;
            seven_seg_q   <= 8'hFF;
        end else begin
            active_dig_q  <= active_dig_d;
            active_dp_q   <= active_dp_d;
            shadow_dig_q  <= shadow_dig_d;
            shadow_dp_q   <= shadow_dp_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            seg_drv_q     <= seg_drv_d;
            seven_seg_q   <= seven_seg_d;
        end
    end

    always_comb begin
        active_dig_d  = active_dig_q;
        active_dp_d   = active_dp_q;
        shadow_dig_d  = shadow_dig_q;
        shadow_dp_d   = shadow_dp_q;
        pending_d     = pending_q;
        capture       = ld.Load_Valid && !pending_q;
        // Capture and transfer are exclusive: a full shadow is never ready.
        if (capture) begin
            shadow_dig_d = ld.Digits_In;
            shadow_dp_d  = ld.Dp_In;
            pending_d    = 1'b1;
        end else if (frame_boundary && pending_q) begin
            active_dig_d = shadow_dig_q;
            active_dp_d  = shadow_dp_q;
            pending_d    = 1'b0;
        end

        frame_start_d = frame_boundary;
        cur_digit     = active_dig_q[{digit_idx, 2'b00} +: 4];
        cur_dp        = active_dp_q[digit_idx];
        seg_drv_d     = '1;
        seven_seg_d   = 8'hFF;
        if (lit && !blank_mask[digit_idx]) begin
            seg_drv_d   = ~(NUM_DIGITS'(1) << digit_idx);
            seven_seg_d = {~cur_dp, ~hex_to_seg(cur_digit)};
        end
    end

    assign ld.Load_Ready   = !pending_q;
    assign Frame_Start     = frame_start_q;
    assign SegmentDrivers  = seg_drv_q;
    assign SevenSegment    = seven_seg_q;

endmodule
